// File: rtl/fetch_decode_register.sv
// IF/ID stage register: two-entry skid buffer between Fetch and Decode.
// Optional FETCH_DECODE_NOP_INSERT_EN drives NOP_INSTR on bubbles.
module fetch_decode_register #(
    parameter int                     WIDTH       = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       FetchPC,
    input  logic [WIDTH-1:0]       FetchPCPlus8,
    input  logic [INSTR_WIDTH-1:0] FetchInstruction,
    input  logic                   FetchValid,
    output logic                   FetchReady,
    input  logic                   Flush,
    input  logic                   DecodeReady,
    output logic                   DecodeValid,
    output logic [WIDTH-1:0]       DecodePC,
    output logic [WIDTH-1:0]       DecodePCPlus8,
    output logic [INSTR_WIDTH-1:0] DecodeInstruction
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0]       pc;
        logic [WIDTH-1:0]       pc_plus8;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t fetch_entry;
    logic   push;
    logic   pop;

    assign fetch_entry = '{
        pc:       FetchPC,
        pc_plus8: FetchPCPlus8,
        instr:    FetchInstruction
    };

    // Handshake outputs come only from state flops and reset
    assign FetchReady  = (state_q != FULL) & reset;
    assign DecodeValid = (state_q != EMPTY);

    assign push = FetchValid & FetchReady;
    assign pop  = DecodeValid & DecodeReady;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = HALF;
                        head_d  = fetch_entry;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        head_d = fetch_entry;
                    end else if (push) begin
                        state_d = FULL;
                        tail_d  = fetch_entry;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = HALF;
                        head_d  = tail_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign DecodePC      = head_q.pc;
    assign DecodePCPlus8 = head_q.pc_plus8;

`ifdef FETCH_DECODE_NOP_INSERT_EN
    assign DecodeInstruction = DecodeValid ? head_q.instr : NOP_INSTR;
`else
    logic unused_nop_instr;
    assign unused_nop_instr  = ^NOP_INSTR;
    assign DecodeInstruction = head_q.instr;
`endif

endmodule
